// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants, state encoding and helpers for the 4:1 mux arbiter
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rtl/mux_rr_arbiter_rr_pick.sv - rotating priority encoder: first set request at or after ptr
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    idx  = ptr;
    cand = ptr;
    any  = |req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + i[IDX_W-1:0];
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin owner sequencer for the shared 4:1 output mux
// Optional MUX_ARB_PRIO0_EN: requester 0 always wins arbitration and does not advance the pointer.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_TENURE = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   sel,
  output logic               valid,
  output logic               busy,
  output logic               expired
);

  localparam logic [7:0] TEN_LAST = 8'(MAX_TENURE - 1);
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t             state, state_d;
  logic [7:0]         cnt, cnt_d;
  logic [3:0]         gap_cnt, gap_cnt_d;
  logic [IDX_W-1:0]   ptr, ptr_d;
  logic [IDX_W-1:0]   sel_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic               expired_d;

  logic [IDX_W-1:0]   pick_idx, win_idx, ptr_rel;
  logic               pick_any, owner_drop, tenure_hit;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef MUX_ARB_PRIO0_EN
  assign win_idx = req[0] ? '0 : pick_idx;
  assign ptr_rel = (sel == '0) ? ptr : sel + 1'b1;
`else
  assign win_idx = pick_idx;
  assign ptr_rel = sel + 1'b1;
`endif

  // sel tracks the owner for the whole tenure, so it doubles as the owner index.
  assign owner_drop = !req[sel];
  assign tenure_hit = (cnt == TEN_LAST);

  assign valid = |gnt;
  assign busy  = (state != IDLE);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    gap_cnt_d = gap_cnt;
    ptr_d     = ptr;
    sel_d     = sel;
    gnt_d     = gnt;
    expired_d = 1'b0;
    case (state)
      IDLE: begin
        if (en && pick_any) begin
          state_d = GRANT;
          gnt_d   = onehot(win_idx);
          sel_d   = win_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (owner_drop || tenure_hit) begin
          // A voluntary drop takes precedence over a coincident expiry.
          expired_d = !owner_drop;
          gnt_d     = '0;
          ptr_d     = ptr_rel;
          cnt_d     = '0;
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else if (cnt != 8'hFF) begin
          cnt_d = cnt + 8'd1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      gap_cnt <= '0;
      ptr     <= '0;
      sel     <= '0;
      gnt     <= '0;
      expired <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      gap_cnt <= gap_cnt_d;
      ptr     <= ptr_d;
      sel     <= sel_d;
      gnt     <= gnt_d;
      expired <= expired_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - scoreboard bench for mux_rr_arbiter (MAX_TENURE=4, GAP_CYCLES=1)
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       busy;
  logic       expired;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [3:0] exp_q[$];

  mux_rr_arbiter #(
    .MAX_TENURE (4),
    .GAP_CYCLES (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .valid   (valid),
    .busy    (busy),
    .expired (expired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic wait_gnt(input int limit, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (gnt !== 4'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no grant within %0d cycles, gnt=%b", name, limit, gnt);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b0 && gnt === 4'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: arbiter not idle, busy=%b gnt=%b", name, busy, gnt);
    end
  endtask

  task automatic check_gnt(input string name);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: grant with empty scoreboard, gnt=%b", name, gnt);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (gnt !== e) begin
        errors++;
        $display("FAIL %s gnt: got %b expected %b", name, gnt, e);
      end
      checks++;
      if (sel !== idx_of(e)) begin
        errors++;
        $display("FAIL %s sel: got %0d expected %0d", name, sel, idx_of(e));
      end
      checks++;
      if (valid !== 1'b1) begin
        errors++;
        $display("FAIL %s valid: got %b expected 1", name, valid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    req = 4'b0;
    tick();
    tick();
    checks++;
    if ({gnt, sel, valid, busy, expired} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state: got gnt=%b sel=%0d valid=%b busy=%b expired=%b expected all 0",
               gnt, sel, valid, busy, expired);
    end
    rst = 1'b0;
    en  = 1'b1;
    tick();
  endtask

  task automatic test_single_handoff();
    wait_idle("single_pre");
    req = 4'b0100;
    exp_q.push_back(4'b0100);
    tick();
    check_gnt("single_grant");
    tick();
    tick();
    req = 4'b0;
    tick();
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b1 || expired !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got gnt=%b busy=%b expired=%b expected 0000/1/0", gnt, busy, expired);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || sel !== 2'd2) begin
      errors++;
      $display("FAIL single_idle: got busy=%b sel=%0d expected 0/2", busy, sel);
    end
  endtask

  task automatic test_pointer_skip();
    wait_idle("skip_pre");
    req = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_gnt(6, "skip_first_timeout");
    check_gnt("skip_first");
    req = 4'b0;
    tick();
    req = 4'b1010;
    exp_q.push_back(4'b1000);
    wait_gnt(6, "skip_second_timeout");
    check_gnt("skip_second");
    req = 4'b0;
    wait_idle("skip_post");
  endtask

  task automatic test_full_rotation();
    int prev;
    int len;
    wait_idle("rot_pre");
`ifdef MUX_ARB_PRIO0_EN
    for (int k = 0; k < 5; k++) exp_q.push_back(4'b0001);
`else
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
`endif
    req  = 4'b1111;
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(10, "rot_timeout");
      check_gnt($sformatf("rot%0d", k));
      if (prev >= 0) begin
        checks++;
        if (cyc - prev !== 6) begin
          errors++;
          $display("FAIL rot%0d period: got %0d expected 6", k, cyc - prev);
        end
      end
      prev = cyc;
      len  = 0;
      while (gnt !== 4'b0 && len < 10) begin
        len++;
        tick();
      end
      checks++;
      if (len !== 4) begin
        errors++;
        $display("FAIL rot%0d tenure: got %0d expected 4", k, len);
      end
      checks++;
      if (expired !== 1'b1) begin
        errors++;
        $display("FAIL rot%0d expired: got %b expected 1", k, expired);
      end
      tick();
      checks++;
      if (expired !== 1'b0) begin
        errors++;
        $display("FAIL rot%0d expired_pulse: got %b expected 0", k, expired);
      end
    end
    req = 4'b0;
    wait_idle("rot_post");
  endtask

  task automatic test_en_gating();
    wait_idle("en_pre");
    en  = 1'b0;
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (gnt !== 4'b0) begin
        errors++;
        $display("FAIL en_block%0d: got gnt=%b expected 0000", i, gnt);
      end
    end
    en = 1'b1;
    exp_q.push_back(4'b0001);
    tick();
    check_gnt("en_grant");
    en = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL en_hold: got gnt=%b expected 0001", gnt);
    end
    tick();
    tick();
    req = 4'b0;
    tick();
    checks++;
    if (gnt !== 4'b0 || expired !== 1'b0) begin
      errors++;
      $display("FAIL drop_vs_expiry: got gnt=%b expired=%b expected 0000/0", gnt, expired);
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    wait_idle("rstmid_pre");
    req = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_gnt(4, "rstmid_timeout");
    check_gnt("rstmid_grant");
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, sel, valid, busy, expired} !== 9'b0) begin
      errors++;
      $display("FAIL reset_mid: got gnt=%b sel=%0d valid=%b busy=%b expired=%b expected all 0",
               gnt, sel, valid, busy, expired);
    end
    tick();
    req = 4'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || expired !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: got busy=%b expired=%b expected 0/0", busy, expired);
    end
  endtask

  initial begin
    test_reset();
    test_single_handoff();
    test_pointer_skip();
    test_full_rotation();
    test_en_gating();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
